// File: rtl/bus_pkg.sv
// Shared types, region encoding and default timing constants for the
// 68k bus cycle sequencer.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  typedef enum logic [2:0] {
    REG_UNMAP = 3'd0,
    REG_RAM   = 3'd1,
    REG_ROM   = 3'd2,
    REG_IO    = 3'd3,
    REG_GFX   = 3'd4,
    REG_CTRL  = 3'd5
  } region_t;

  localparam int ROM_WAIT_DEF = 2;
  localparam int RAM_WAIT_DEF = 1;
  localparam int REG_WAIT_DEF = 0;
  localparam int IO_WAIT_DEF  = 3;
  localparam int GFX_WAIT_DEF = 1;
  localparam int TIMEOUT_DEF  = 255;

  localparam int TIMEOUT_W = 8;
  localparam int WAIT_W    = 8;

  // Mapper chip selects in a fixed order; unmap sits in the MSB.
  typedef struct packed {
    logic unmap;
    logic ram1;
    logic ram2;
    logic rom;
    logic io;
    logic gfx;
    logic ctrl;
    logic pgtbl;
  } cs_t;

  // Anything other than exactly one real chip select is a bus error.
  function automatic region_t cs_decode(input cs_t cs);
    logic [7:0] bits;
    logic [3:0] hits;
    region_t    region;
    bits   = cs;
    hits   = '0;
    region = REG_UNMAP;
    for (int i = 0; i < 8; i++) begin
      hits = hits + {3'b000, bits[i]};
    end
    if (hits == 4'd1 && !cs.unmap) begin
      if (cs.ram1 || cs.ram2) begin
        region = REG_RAM;
      end else if (cs.rom) begin
        region = REG_ROM;
      end else if (cs.io) begin
        region = REG_IO;
      end else if (cs.gfx) begin
        region = REG_GFX;
      end else begin
        region = REG_CTRL;
      end
    end
    return region;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for asynchronous inputs, with the reset value
// chosen so the synchronized signal starts in its inactive level.
module sync_ff2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_cycle_ctl.sv
// 68k bus cycle sequencer: enables the mapper, decodes its chip selects,
// inserts wait states and terminates with DTACK or bus error.
// Optional feature macro: BUS_TIMEOUT_EN (forced bus error on a stalled cycle).
module bus_cycle_ctl
  import bus_pkg::*;
#(
  parameter int ROM_WAIT = ROM_WAIT_DEF,
  parameter int RAM_WAIT = RAM_WAIT_DEF,
  parameter int REG_WAIT = REG_WAIT_DEF,
  parameter int IO_WAIT  = IO_WAIT_DEF,
  parameter int GFX_WAIT = GFX_WAIT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic as_n,
  input  logic pas,
  input  logic csunmap,
  input  logic csram1,
  input  logic csram2,
  input  logic csrom,
  input  logic csio,
  input  logic csgfx,
  input  logic csctrl,
  input  logic cspgtbl,
  input  logic io_ready,
  input  logic gfx_ready,
  output logic map_enable,
  output logic dtack_n,
  output logic berr_n,
  output logic busy
);

  state_t              state;
  region_t             region;
  region_t             hit_region;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_load;
  logic                as_n_sync;
  logic                as_s;
  logic                ready_ok;
  logic                timeout_hit;
  cs_t                 cs_in;

  sync_ff2 #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_as_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (as_n),
    .q     (as_n_sync)
  );

  assign as_s = ~as_n_sync;

  assign cs_in = '{
    unmap: csunmap,
    ram1:  csram1,
    ram2:  csram2,
    rom:   csrom,
    io:    csio,
    gfx:   csgfx,
    ctrl:  csctrl,
    pgtbl: cspgtbl
  };

  assign hit_region = cs_decode(cs_in);

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wait_load = '0;
    unique case (hit_region)
      REG_RAM:  wait_load = WAIT_W'(RAM_WAIT);
      REG_ROM:  wait_load = WAIT_W'(ROM_WAIT);
      REG_IO:   wait_load = WAIT_W'(IO_WAIT);
      REG_GFX:  wait_load = WAIT_W'(GFX_WAIT);
      REG_CTRL: wait_load = WAIT_W'(REG_WAIT);
      default:  wait_load = '0;
    endcase
  end

  // Slow devices only finish once their handshake line is up.
  always_comb begin
    ready_ok = 1'b1;
    unique case (region)
      REG_IO:  ready_ok = io_ready;
      REG_GFX: ready_ok = gfx_ready;
      default: ready_ok = 1'b1;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE) begin
      to_cnt <= '0;
    end else if (state == ST_REQ || state == ST_WAIT) begin
      to_cnt <= to_cnt + TIMEOUT_W'(1);
    end
  end

  // Fires on the edge where the count would reach TIMEOUT, i.e. exactly
  // TIMEOUT cycles after leaving IDLE.
  assign timeout_hit = (state == ST_REQ || state == ST_WAIT) &&
                       (to_cnt == TIMEOUT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of all the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      region     <= REG_UNMAP;
      wait_cnt   <= '0;
      map_enable <= 1'b0;
      dtack_n    <= 1'b1;
      berr_n     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (as_s) begin
            state      <= ST_REQ;
            map_enable <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_REQ: begin
          if (!as_s) begin
            state      <= ST_IDLE;
            map_enable <= 1'b0;
            busy       <= 1'b0;
          end else if (timeout_hit) begin
            state  <= ST_BERR;
            berr_n <= 1'b0;
          end else if (pas) begin
            if (hit_region == REG_UNMAP) begin
              state  <= ST_BERR;
              berr_n <= 1'b0;
            end else begin
              state    <= ST_WAIT;
              region   <= hit_region;
              wait_cnt <= wait_load;
            end
          end
        end

        ST_WAIT: begin
          if (!as_s) begin
            state      <= ST_IDLE;
            map_enable <= 1'b0;
            busy       <= 1'b0;
          end else if (timeout_hit) begin
            state  <= ST_BERR;
            berr_n <= 1'b0;
          end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (ready_ok) begin
            state   <= ST_ACK;
            dtack_n <= 1'b0;
          end
        end

        ST_ACK: begin
          if (!as_s) begin
            state      <= ST_IDLE;
            dtack_n    <= 1'b1;
            map_enable <= 1'b0;
            busy       <= 1'b0;
          end
        end

        ST_BERR: begin
          if (!as_s) begin
            state      <= ST_IDLE;
            berr_n     <= 1'b1;
            map_enable <= 1'b0;
            busy       <= 1'b0;
          end
        end

        default: begin
          state      <= ST_IDLE;
          map_enable <= 1'b0;
          dtack_n    <= 1'b1;
          berr_n     <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctl.sv
// Self-checking bench for bus_cycle_ctl with a registered mapper model
// (map_enable -> enable register -> pas) and a queue of expected terminations.
module tb_bus_cycle_ctl;

  localparam int BUDGET = 400;

  localparam logic [7:0] CS_NONE  = 8'h00;
  localparam logic [7:0] CS_UNMAP = 8'h80;
  localparam logic [7:0] CS_RAM1  = 8'h40;
  localparam logic [7:0] CS_RAM2  = 8'h20;
  localparam logic [7:0] CS_ROM   = 8'h10;
  localparam logic [7:0] CS_IO    = 8'h08;
  localparam logic [7:0] CS_GFX   = 8'h04;
  localparam logic [7:0] CS_CTRL  = 8'h02;
  localparam logic [7:0] CS_PGTBL = 8'h01;

  // {dtack_n, berr_n} while a cycle is being terminated
  localparam logic [1:0] TERM_ACK  = 2'b01;
  localparam logic [1:0] TERM_BERR = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       as_n;
  logic       pas;
  logic       en_q;
  logic [7:0] cs_cfg;
  logic       io_ready;
  logic       gfx_ready;
  logic       csunmap, csram1, csram2, csrom, csio, csgfx, csctrl, cspgtbl;
  logic       map_enable, dtack_n, berr_n, busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [1:0] term;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #10 clk = ~clk;

  // Mapper model: registers the enable, then presents pas a cycle later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= 1'b0;
      pas  <= 1'b0;
    end else begin
      en_q <= map_enable;
      pas  <= en_q;
    end
  end

  assign csunmap = pas & cs_cfg[7];
  assign csram1  = pas & cs_cfg[6];
  assign csram2  = pas & cs_cfg[5];
  assign csrom   = pas & cs_cfg[4];
  assign csio    = pas & cs_cfg[3];
  assign csgfx   = pas & cs_cfg[2];
  assign csctrl  = pas & cs_cfg[1];
  assign cspgtbl = pas & cs_cfg[0];

  bus_cycle_ctl #(
    .TIMEOUT (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .as_n       (as_n),
    .pas        (pas),
    .csunmap    (csunmap),
    .csram1     (csram1),
    .csram2     (csram2),
    .csrom      (csrom),
    .csio       (csio),
    .csgfx      (csgfx),
    .csctrl     (csctrl),
    .cspgtbl    (cspgtbl),
    .io_ready   (io_ready),
    .gfx_ready  (gfx_ready),
    .map_enable (map_enable),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n),
    .busy       (busy)
  );

  // Counts clock edges until dtack_n or berr_n goes low, bounded.
  task automatic wait_term(output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!dtack_n || !berr_n) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_term(input exp_t e, input int lat, input bit seen);
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no termination within %0d clk, required %b after %0d clk",
               e.name, BUDGET, e.term, e.lat);
      return;
    end
    checks++;
    if ({dtack_n, berr_n} !== e.term) begin
      errors++;
      $display("FAIL %s strobes: got {dtack_n,berr_n}=%b, required %b", e.name, {dtack_n, berr_n}, e.term);
    end
    checks++;
    if (lat !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d clk, required %0d clk", e.name, lat, e.lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy during termination: got %b, required 1", e.name, busy);
    end
  endtask

  // Releases as_n and checks the strobes rise 3 clk later with the mapper off.
  task automatic release_cycle(input string name);
    int rel;
    rel = 0;
    @(posedge clk);
    #1 as_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (dtack_n && berr_n) begin
        rel = k;
        break;
      end
    end
    checks++;
    if (rel !== 3) begin
      errors++;
      $display("FAIL %s release latency: got %0d clk, required 3 clk", name, rel);
    end
    checks++;
    if (map_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after release: got map_enable=%b busy=%b, required 0 0", name, map_enable, busy);
    end
  endtask

  task automatic bus_cycle(input string name, input logic [7:0] cs, input logic [1:0] term,
                           input int lat_exp);
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    cs_cfg = cs;
    @(posedge clk);
    #1 as_n = 1'b0;
    e.name = name;
    e.term = term;
    e.lat  = lat_exp;
    sb.push_back(e);
    wait_term(lat, seen);
    got = sb.pop_front();
    check_term(got, lat, seen);
    release_cycle(name);
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    as_n      = 1'b1;
    cs_cfg    = CS_NONE;
    io_ready  = 1'b0;
    gfx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (dtack_n !== 1'b1) begin errors++; $display("FAIL reset dtack_n: got %b, required 1", dtack_n); end
    checks++;
    if (berr_n !== 1'b1) begin errors++; $display("FAIL reset berr_n: got %b, required 1", berr_n); end
    checks++;
    if (map_enable !== 1'b0) begin errors++; $display("FAIL reset map_enable: got %b, required 0", map_enable); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
  endtask

  // Latency from as_n fall: 2 sync + 1 enable + 2 mapper + 1 sample + (wait+1).
  task automatic test_regions;
    gfx_ready = 1'b1;
    bus_cycle("ram1",  CS_RAM1,  TERM_ACK, 8);
    bus_cycle("ram2",  CS_RAM2,  TERM_ACK, 8);
    bus_cycle("rom",   CS_ROM,   TERM_ACK, 9);
    bus_cycle("ctrl",  CS_CTRL,  TERM_ACK, 7);
    bus_cycle("pgtbl", CS_PGTBL, TERM_ACK, 7);
    bus_cycle("gfx",   CS_GFX,   TERM_ACK, 8);
    gfx_ready = 1'b0;
  endtask

  task automatic test_unmapped;
    bus_cycle("unmap",       CS_UNMAP,           TERM_BERR, 6);
    bus_cycle("multi_cs",    CS_RAM1 | CS_ROM,   TERM_BERR, 6);
    bus_cycle("no_cs",       CS_NONE,            TERM_BERR, 6);
    bus_cycle("unmap_plus",  CS_UNMAP | CS_RAM1, TERM_BERR, 6);
  endtask

  // Wait counter is 1 at edge 9 (pulse must be ignored); ready held from edge 13.
  task automatic test_io_handshake;
    io_ready = 1'b0;
    fork
      begin
        @(negedge as_n);
        repeat (8) @(posedge clk);
        #1 io_ready = 1'b1;
        @(posedge clk);
        #1 io_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 io_ready = 1'b1;
      end
      bus_cycle("io", CS_IO, TERM_ACK, 13);
    join
    io_ready = 1'b0;
  endtask

  task automatic test_timeout;
    gfx_ready = 1'b0;
`ifdef BUS_TIMEOUT_EN
    // Leaves IDLE at edge 3, bus error 20 clk later.
    bus_cycle("timeout", CS_GFX, TERM_BERR, 23);
`else
    begin
      bit any_low;
      any_low = 1'b0;
      cs_cfg  = CS_GFX;
      @(posedge clk);
      #1 as_n = 1'b0;
      repeat (300) begin
        @(posedge clk);
        @(negedge clk);
        if (!dtack_n || !berr_n) any_low = 1'b1;
      end
      checks++;
      if (any_low !== 1'b0) begin
        errors++;
        $display("FAIL stall: got a termination strobe within 300 clk, required none");
      end
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL stall busy: got %b, required 1", busy); end
      @(posedge clk);
      #1 as_n = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || map_enable !== 1'b0) begin
        errors++;
        $display("FAIL stall release: got busy=%b map_enable=%b, required 0 0", busy, map_enable);
      end
    end
`endif
  endtask

  // ROM would acknowledge at edge 9; the abort is seen at edge 9 and wins.
  task automatic test_abort;
    bit any_low;
    any_low = 1'b0;
    cs_cfg  = CS_ROM;
    @(posedge clk);
    #1 as_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 as_n = 1'b1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort busy in WAIT: got %b, required 1", busy); end
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (!dtack_n || !berr_n) any_low = 1'b1;
    end
    checks++;
    if (any_low !== 1'b0) begin
      errors++;
      $display("FAIL abort: got a termination strobe after as_n rise, required none");
    end
    checks++;
    if (busy !== 1'b0 || map_enable !== 1'b0) begin
      errors++;
      $display("FAIL abort idle: got busy=%b map_enable=%b, required 0 0", busy, map_enable);
    end
  endtask

  task automatic test_reset_in_ack;
    exp_t e;
    exp_t got;
    int   lat;
    bit   seen;
    cs_cfg = CS_CTRL;
    @(posedge clk);
    #1 as_n = 1'b0;
    e.name = "ack_before_reset";
    e.term = TERM_ACK;
    e.lat  = 7;
    sb.push_back(e);
    wait_term(lat, seen);
    got = sb.pop_front();
    check_term(got, lat, seen);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
      errors++;
      $display("FAIL async reset strobes: got dtack_n=%b berr_n=%b, required 1 1", dtack_n, berr_n);
    end
    checks++;
    if (map_enable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async reset ctl: got map_enable=%b busy=%b, required 0 0", map_enable, busy);
    end
    as_n = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (dtack_n !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after reset release: got dtack_n=%b busy=%b, required 1 0", dtack_n, busy);
    end
  endtask

  task automatic test_back_to_back;
    bus_cycle("b2b_ram1",  CS_RAM1,  TERM_ACK,  8);
    bus_cycle("b2b_unmap", CS_UNMAP, TERM_BERR, 6);
    bus_cycle("b2b_rom",   CS_ROM,   TERM_ACK,  9);
    bus_cycle("b2b_ctrl",  CS_CTRL,  TERM_ACK,  7);
  endtask

  initial begin
    test_reset();
    test_regions();
    test_unmapped();
    test_io_handshake();
    test_timeout();
    test_abort();
    test_reset_in_ack();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d entries left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
